// File: rtl/systolic_ctrl_pkg.sv
// Shared definitions for the systolic tile controller.
//   tile_state_t : sequencer state encoding
//   cyc_width()  : width of the COMPUTE cycle counter for a given N / pipe latency
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    READ,
    DONE
  } tile_state_t;

  function automatic int cyc_width(input int n, input int pipe_lat);
    return $clog2(pipe_lat + 2 * n);
  endfunction

endpackage

// File: rtl/tile_perf_counter.sv
// Saturating busy-cycle counter for one tile pass.
//   clk, rst_n  : clock, async active-low reset
//   i_clear     : hold the running count at zero (controller idle)
//   i_count     : count this cycle (controller busy)
//   i_capture   : latch running count, including this cycle, into o_count
//   o_count     : last captured tile cycle count
module tile_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_count,
  input  logic        i_capture,
  output logic [31:0] o_count
);

  logic [31:0] r_cnt;
  logic [31:0] r_out;
  logic [31:0] w_inc;

  assign w_inc   = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
  assign o_count = r_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_out <= '0;
    end else begin
      if (i_clear)
        r_cnt <= '0;
      else if (i_count)
        r_cnt <= w_inc;
      // Capture the incremented value so the capture cycle itself is included.
      if (i_capture)
        r_out <= w_inc;
    end
  end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for one matrix tile pass: loads A rows into the skew buffer,
// steps it during compute, opens the reverse-skew capture window at the
// pipeline latency, then drains result rows over a valid/ready port.
//
// Optional feature macro: SYSTOLIC_TILE_CTRL_PERF_EN (adds perf_cycles).
//
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   start                   : begin a tile (IDLE only)
//   busy, done              : not-idle flag, one-cycle completion pulse
//   a_valid / a_ready       : A-row input handshake
//   sk_write, sk_row_ptr    : skew-buffer row write strobe and row index
//   sk_enable               : skew-buffer shift step
//   rsk_enable, rsk_write   : reverse-skew capture strobes (identical)
//   rsk_read                : reverse-skew row pop
//   out_valid / out_ready   : result-row output handshake
//   out_row_idx             : index of presented result row
//   perf_cycles             : busy cycles of the last tile (perf build only)
//
// state   | meaning
// IDLE    | waiting for start, all strobes low
// LOAD    | accepting N A rows into the skew buffer
// COMPUTE | stepping skew buffer / capturing results, fixed length
// READ    | presenting N result rows
// DONE    | one-cycle completion pulse
module systolic_tile_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE = 8,
  parameter int PIPE_LAT   = ARRAY_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic                          a_valid,
  output logic                          a_ready,
  output logic                          sk_write,
  output logic [$clog2(ARRAY_SIZE)-1:0] sk_row_ptr,
  output logic                          sk_enable,
  output logic                          rsk_enable,
  output logic                          rsk_write,
  output logic                          rsk_read,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(ARRAY_SIZE)-1:0] out_row_idx
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_cycles
`endif
);

  localparam int RW = $clog2(ARRAY_SIZE);
  localparam int CW = cyc_width(ARRAY_SIZE, PIPE_LAT);

  localparam logic [RW-1:0] LAST_ROW  = RW'(ARRAY_SIZE - 1);
  localparam logic [CW-1:0] SK_END    = CW'(2 * ARRAY_SIZE - 1);
  localparam logic [CW-1:0] CAP_START = CW'(PIPE_LAT);
  localparam logic [CW-1:0] CYC_LAST  = CW'(PIPE_LAT + 2 * ARRAY_SIZE - 2);

  tile_state_t   r_state;
  tile_state_t   w_state_nxt;
  logic [RW-1:0] r_row_cnt;
  logic [RW-1:0] w_row_cnt_nxt;
  logic [RW-1:0] r_row_idx;
  logic [RW-1:0] w_row_idx_nxt;
  logic [CW-1:0] r_cyc;
  logic [CW-1:0] w_cyc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_row_cnt <= '0;
      r_row_idx <= '0;
      r_cyc     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_cnt_nxt;
      r_row_idx <= w_row_idx_nxt;
      r_cyc     <= w_cyc_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_cnt_nxt = r_row_cnt;
    w_row_idx_nxt = r_row_idx;
    w_cyc_nxt     = r_cyc;
    busy          = (r_state != IDLE);
    done          = 1'b0;
    a_ready       = 1'b0;
    sk_write      = 1'b0;
    sk_row_ptr    = r_row_cnt;
    sk_enable     = 1'b0;
    rsk_enable    = 1'b0;
    rsk_write     = 1'b0;
    rsk_read      = 1'b0;
    out_valid     = 1'b0;
    out_row_idx   = r_row_idx;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt   = LOAD;
          w_row_cnt_nxt = '0;
        end
      end

      LOAD: begin
        a_ready  = 1'b1;
        sk_write = a_valid;
        if (a_valid) begin
          if (r_row_cnt == LAST_ROW) begin
            w_state_nxt   = COMPUTE;
            w_cyc_nxt     = '0;
            w_row_cnt_nxt = '0;
          end else begin
            w_row_cnt_nxt = r_row_cnt + 1'b1;
          end
        end
      end

      COMPUTE: begin
        // Shift and capture windows are independent and may overlap.
        sk_enable  = (r_cyc < SK_END);
        rsk_enable = (r_cyc >= CAP_START);
        rsk_write  = (r_cyc >= CAP_START);
        if (r_cyc == CYC_LAST) begin
          w_state_nxt   = READ;
          w_row_idx_nxt = '0;
          w_cyc_nxt     = '0;
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end

      READ: begin
        out_valid = 1'b1;
        rsk_read  = out_ready;
        if (out_ready) begin
          if (r_row_idx == LAST_ROW) begin
            w_state_nxt   = DONE;
            w_row_idx_nxt = '0;
          end else begin
            w_row_idx_nxt = r_row_idx + 1'b1;
          end
        end
      end

      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  logic w_idle;
  logic w_in_done;

  assign w_idle    = (r_state == IDLE);
  assign w_in_done = (r_state == DONE);

  tile_perf_counter u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_idle),
    .i_count   (busy),
    .i_capture (w_in_done),
    .o_count   (perf_cycles)
  );
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
module tb_systolic_tile_ctrl;

  localparam int N    = 4;
  localparam int PL   = 4;
  localparam int MAXC = 120;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, done, a_ready, sk_write, sk_enable;
  logic       rsk_enable, rsk_write, rsk_read, out_valid;
  logic [1:0] sk_row_ptr, out_row_idx;
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  systolic_tile_ctrl #(.ARRAY_SIZE(N), .PIPE_LAT(PL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .sk_write    (sk_write),
    .sk_row_ptr  (sk_row_ptr),
    .sk_enable   (sk_enable),
    .rsk_enable  (rsk_enable),
    .rsk_write   (rsk_write),
    .rsk_read    (rsk_read),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row_idx (out_row_idx)
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stimulus per tile cycle (cycle 0 = first LOAD cycle)
  bit av [MAXC];
  bit orr[MAXC];
  bit stm[MAXC];

  // reference model results
  int e_load, e_read_start, e_read_len, e_total;

  // recorded trace
  logic       t_busy[MAXC], t_done[MAXC], t_ar[MAXC], t_wr[MAXC], t_sken[MAXC];
  logic       t_rske[MAXC], t_rskw[MAXC], t_rd[MAXC], t_ov[MAXC];
  logic [1:0] t_ptr[MAXC], t_idx[MAXC];
  int         n_cyc;
  bit         timed_out;
  logic       post_busy, post_done;
  logic [31:0] post_perf;

  // trace summary
  int n_wr, wr_noav, n_ar, sken_first, sken_n, sken_last, rsk_first, rsk_n, rsk_last;
  int rsk_neq, ov_first, ov_n, pop_n, pop_bad, done_n, busy_low;
  logic [7:0] wr_seq, pop_seq;

  task automatic gen_av(input int mode);
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        0: av[c] = 1'b1;
        1: av[c] = (c % 2 == 0);
        default: av[c] = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      stm[c] = 1'b0;
    end
    begin
      int cnt = 0;
      e_load = -1;
      for (int c = 0; c < MAXC; c++) begin
        if (av[c]) cnt++;
        if (cnt == N) begin e_load = c + 1; break; end
      end
    end
    // COMPUTE length is fixed: PIPE_LAT + 2N - 1 cycles
    e_read_start = e_load + PL + 2 * N - 1;
  endtask

  task automatic gen_or(input int mode);
    int cnt = 0;
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        0: orr[c] = 1'b1;
        1: orr[c] = !(c >= e_read_start + 2 && c <= e_read_start + 4);
        default: orr[c] = (c >= e_read_start + 30) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
    end
    e_read_len = -1;
    for (int c = e_read_start; c < MAXC; c++) begin
      if (orr[c]) cnt++;
      if (cnt == N) begin e_read_len = c - e_read_start + 1; break; end
    end
    e_total = e_read_start + e_read_len + 1;
  endtask

  task automatic run_tile(input bit chained, input bit chain_next);
    if (!chained) begin
      @(posedge clk); #1;
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    n_cyc = MAXC;
    for (int c = 0; c < MAXC; c++) begin
      a_valid   = av[c];
      out_ready = orr[c];
      start     = stm[c];
      @(negedge clk);
      t_busy[c] = busy;  t_done[c] = done;  t_ar[c]  = a_ready;  t_wr[c]  = sk_write;
      t_sken[c] = sk_enable; t_rske[c] = rsk_enable; t_rskw[c] = rsk_write;
      t_rd[c]   = rsk_read;  t_ov[c]   = out_valid;  t_ptr[c]  = sk_row_ptr;
      t_idx[c]  = out_row_idx;
      if (done) begin n_cyc = c + 1; timed_out = 1'b0; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = chain_next;
    a_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    post_busy = busy;
    post_done = done;
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    post_perf = perf_cycles;
`else
    post_perf = 32'(e_total);
`endif
    // reduce trace to counts and first/last positions
    n_wr = 0; wr_noav = 0; n_ar = 0; sken_first = -1; sken_n = 0; sken_last = -1;
    rsk_first = -1; rsk_n = 0; rsk_last = -1; rsk_neq = 0; ov_first = -1; ov_n = 0;
    pop_n = 0; pop_bad = 0; done_n = 0; busy_low = 0; wr_seq = '0; pop_seq = '0;
    for (int c = 0; c < n_cyc; c++) begin
      if (t_wr[c] === 1'b1) begin n_wr++; wr_seq = {wr_seq[5:0], t_ptr[c]}; end
      if (t_wr[c] !== (av[c] & t_ar[c])) wr_noav++;
      if (t_ar[c] === 1'b1) n_ar++;
      if (t_sken[c] === 1'b1) begin if (sken_first < 0) sken_first = c; sken_n++; sken_last = c; end
      if (t_rskw[c] === 1'b1) begin if (rsk_first < 0) rsk_first = c; rsk_n++; rsk_last = c; end
      if (t_rske[c] !== t_rskw[c]) rsk_neq++;
      if (t_ov[c] === 1'b1) begin if (ov_first < 0) ov_first = c; ov_n++; end
      if (t_rd[c] === 1'b1) begin pop_n++; pop_seq = {pop_seq[5:0], t_idx[c]}; end
      if (t_rd[c] !== (t_ov[c] & orr[c])) pop_bad++;
      if (t_done[c] === 1'b1) done_n++;
      if (t_busy[c] !== 1'b1) busy_low++;
    end
  endtask

  task automatic check_tile_trace(input string nm);
    total++; if (timed_out) begin bad++; $display("FAIL %s/timeout: no done within %0d cycles", nm, MAXC); end
    total++; if (n_cyc !== e_total) begin bad++; $display("FAIL %s/tile_len: got %0d want %0d", nm, n_cyc, e_total); end
    total++; if (n_ar !== e_load) begin bad++; $display("FAIL %s/load_len: got %0d want %0d", nm, n_ar, e_load); end
    total++; if (n_wr !== N || wr_seq !== 8'h1B) begin bad++; $display("FAIL %s/sk_write: got n=%0d seq=%h want n=%0d seq=1b", nm, n_wr, wr_seq, N); end
    total++; if (wr_noav !== 0) begin bad++; $display("FAIL %s/sk_write_and: got %0d bad cycles want 0", nm, wr_noav); end
    total++; if (sken_first !== e_load || sken_n !== 2*N-1 || sken_last !== e_load+2*N-2) begin bad++;
      $display("FAIL %s/sk_enable: got first=%0d n=%0d last=%0d want %0d %0d %0d", nm, sken_first, sken_n, sken_last, e_load, 2*N-1, e_load+2*N-2); end
    total++; if (rsk_first !== e_load+PL || rsk_n !== 2*N-1 || rsk_last !== e_load+PL+2*N-2) begin bad++;
      $display("FAIL %s/rsk_write: got first=%0d n=%0d last=%0d want %0d %0d %0d", nm, rsk_first, rsk_n, rsk_last, e_load+PL, 2*N-1, e_load+PL+2*N-2); end
    total++; if (rsk_neq !== 0) begin bad++; $display("FAIL %s/rsk_en_eq_wr: got %0d differing cycles want 0", nm, rsk_neq); end
    total++; if (ov_first !== e_read_start || ov_n !== e_read_len) begin bad++;
      $display("FAIL %s/out_valid: got first=%0d n=%0d want %0d %0d", nm, ov_first, ov_n, e_read_start, e_read_len); end
    total++; if (pop_n !== N || pop_seq !== 8'h1B || pop_bad !== 0) begin bad++;
      $display("FAIL %s/rsk_read: got n=%0d idx=%h badhs=%0d want n=%0d idx=1b badhs=0", nm, pop_n, pop_seq, pop_bad, N); end
    total++; if (done_n !== 1 || busy_low !== 0) begin bad++; $display("FAIL %s/done_busy: got done=%0d busylow=%0d want 1 0", nm, done_n, busy_low); end
    total++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin bad++; $display("FAIL %s/after_done: got busy=%b done=%b want 0 0", nm, post_busy, post_done); end
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    total++; if (post_perf !== 32'(e_total)) begin bad++; $display("FAIL %s/perf_cycles: got %0d want %0d", nm, post_perf, e_total); end
`endif
  endtask

  task automatic check_all_reset(input string nm);
    total++;
    if ({busy, done, a_ready, sk_write, sk_row_ptr, sk_enable, rsk_enable, rsk_write,
         rsk_read, out_valid, out_row_idx} !== 13'd0) begin
      bad++;
      $display("FAIL %s: got busy=%b done=%b ar=%b wr=%b ptr=%0d sken=%b rske=%b rskw=%b rd=%b ov=%b idx=%0d want all 0",
               nm, busy, done, a_ready, sk_write, sk_row_ptr, sk_enable, rsk_enable, rsk_write, rsk_read, out_valid, out_row_idx);
    end
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    total++; if (perf_cycles !== 32'd0) begin bad++; $display("FAIL %s/perf: got %0d want 0", nm, perf_cycles); end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_all_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; a_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_all_reset("reset_release");
  endtask

  task automatic test_nominal();
    gen_av(0); gen_or(0);
    run_tile(1'b0, 1'b0);
    check_tile_trace("nominal");
    total++; if (n_cyc !== 20) begin bad++; $display("FAIL nominal/done_at: got %0d want 20", n_cyc); end
  endtask

  task automatic test_a_valid_stall();
    gen_av(1); gen_or(0);
    run_tile(1'b0, 1'b0);
    check_tile_trace("a_valid_stall");
    total++; if (ov_first - sken_first !== 11 || n_ar !== 7) begin bad++;
      $display("FAIL a_valid_stall/lengths: got compute=%0d load=%0d want 11 7", ov_first - sken_first, n_ar); end
  endtask

  task automatic test_out_ready_stall();
    gen_av(0); gen_or(1);
    run_tile(1'b0, 1'b0);
    check_tile_trace("out_ready_stall");
    for (int c = e_read_start + 2; c <= e_read_start + 4; c++) begin
      total++;
      if (t_ov[c] !== 1'b1 || t_idx[c] !== 2'd2 || t_rd[c] !== 1'b0) begin bad++;
        $display("FAIL out_ready_stall/hold c=%0d: got ov=%b idx=%0d rd=%b want 1 2 0", c, t_ov[c], t_idx[c], t_rd[c]); end
    end
  endtask

  task automatic test_back_to_back();
    gen_av(0); gen_or(0);
    stm[e_load + 3] = 1'b1;
    stm[e_read_start + 1] = 1'b1;
    run_tile(1'b0, 1'b1);
    check_tile_trace("b2b_first");
    gen_av(2); gen_or(2);
    run_tile(1'b1, 1'b0);
    check_tile_trace("b2b_second");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; a_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N + 5) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if ({busy, sk_enable, rsk_write, a_ready} !== 4'b1110) begin bad++;
      $display("FAIL reset_mid/cyc5: got busy=%b sken=%b rskw=%b ar=%b want 1 1 1 0", busy, sk_enable, rsk_write, a_ready); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_reset("reset_mid/next_cycle");
    @(posedge clk); #1;
    rst_n = 1'b1; a_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_all_reset("reset_mid/released");
    gen_av(0); gen_or(0);
    run_tile(1'b0, 1'b0);
    check_tile_trace("after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      gen_av(2); gen_or(2);
      run_tile(1'b0, 1'b0);
      check_tile_trace($sformatf("random%0d", k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_a_valid_stall();
    test_out_ready_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_tile_ctrl.md
# systolic_tile_ctrl

Sequencer for one matrix tile pass through the systolic datapath. It loads the A-operand rows into the input skew buffer and steps that buffer while the array computes. It enables capture into the output reverse-skew buffer at the correct latency, then drains result rows through a valid/ready port. It sits between the host-side tile scheduler and the skew-buffer / array / reverse-skew-buffer datapath, and drives every control strobe of that datapath.

## Interface
- ARRAY_SIZE, 8, array dimension N; power of two, ≥2
- PIPE_LAT, ARRAY_SIZE, cycles from first skew-buffer step to first valid result at array bottom; ≥1
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin tile; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- a_valid  in  1  A row present on datapath input
- a_ready  out  1  high in LOAD
- sk_write  out  1  skew-buffer row write (= a_valid & a_ready)
- sk_row_ptr  out  $clog2(ARRAY_SIZE)  row being written
- sk_enable  out  1  skew-buffer shift step
- rsk_enable, rsk_write  out  1 each  reverse-skew capture strobes, always driven equal
- rsk_read  out  1  reverse-skew row pop
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts result row
- out_row_idx  out  $clog2(ARRAY_SIZE)  index of presented row, 0 first

## Operation
- FSM states: IDLE, LOAD, COMPUTE, READ, DONE.
- IDLE: all strobes 0. start=1 → LOAD; row_cnt=0.
- LOAD: a_ready=1. Each cycle with a_valid=1 asserts sk_write, with sk_row_ptr=row_cnt, and then increments row_cnt. After acceptance of row N-1 → COMPUTE; cyc=0.
- COMPUTE: cyc counts 0..PIPE_LAT+2N-2.
  - sk_enable=1 while cyc<2N-1.
  - rsk_enable=rsk_write=1 while cyc≥PIPE_LAT. This gives exactly 2N-1 capture cycles.
  - At cyc=PIPE_LAT+2N-2 → READ; row_idx=0.
  - The sk_enable and capture windows may overlap; both strobes are then high together.
- READ: out_valid=1 and out_row_idx=row_idx. On out_valid & out_ready, rsk_read=1 for that cycle and row_idx increments. The handshake for row N-1 → DONE.
- DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored. It is not queued.
- The reverse-skew read pointer wraps after N pops, so no explicit re-arm is needed between tiles.
- cyc width: $clog2(PIPE_LAT+2*ARRAY_SIZE). row counters: $clog2(ARRAY_SIZE), no wrap inside a state.

## Timing
- Reset: state=IDLE, all counters 0.
  - Outputs: busy=0, done=0, a_ready=0, sk_write=0, sk_row_ptr=0, sk_enable=0, rsk_enable=rsk_write=0, rsk_read=0, out_valid=0, out_row_idx=0.
- All outputs are registered state decodes, except sk_write and rsk_read, which are combinational ANDs with a_valid and out_ready.
- start high at edge k → LOAD and busy=1 from cycle k+1.
- Minimum tile time with no stalls: N (LOAD) + PIPE_LAT+2N-1 (COMPUTE) + N (READ) + 1 (DONE) cycles.
- a_valid low stalls LOAD. out_ready low stalls READ. COMPUTE never stalls.
- Reset asserted mid-tile returns to IDLE immediately. The datapath buffers are reset by the same rst_n.

## Configuration
- SYSTOLIC_TILE_CTRL_PERF_EN defined:
  - Adds output perf_cycles [31:0].
  - It counts cycles with busy=1 for the current tile, cleared on leaving IDLE.
  - The count is captured into the output register in DONE, so it includes the DONE cycle.
  - The counter saturates at 2^32-1. Reset value 0.
- Not defined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package systolic_ctrl_pkg:
  - state enum tile_state_t.
  - function cyc_width(N, PIPE_LAT) returning $clog2(PIPE_LAT+2*N).
- Sub-module tile_perf_counter holds the saturating counter. It is instantiated only under SYSTOLIC_TILE_CTRL_PERF_EN.

## Test plan
All scenarios use ARRAY_SIZE=4, PIPE_LAT=4.
- Nominal tile, a_valid and out_ready held 1, start pulse:
  - sk_write on 4 cycles with sk_row_ptr 0,1,2,3.
  - sk_enable on 7 cycles.
  - rsk_write on 7 cycles, starting 4 cycles after the first sk_enable.
  - rsk_read on 4 cycles with out_row_idx 0..3.
  - done 20 cycles after LOAD entry; perf_cycles=20.
- a_valid low on alternate LOAD cycles → 4 writes over 7 cycles; ptr sequence unchanged; COMPUTE length still 11.
- out_ready low for 3 cycles at row 2 → out_valid held, out_row_idx=2, rsk_read=0 for those 3 cycles; exactly 4 pops total.
- start pulsed during COMPUTE and READ → ignored, single done; start in the cycle after done begins the next tile. The second tile's rows read back correctly (wrap check).
- rst_n low during COMPUTE cyc=5 → next cycle all outputs at reset values; a following start completes a normal tile.
- Build without SYSTOLIC_TILE_CTRL_PERF_EN → no perf_cycles port; strobe trace identical to the nominal scenario.
